issue_dispatch_buffer: RTL

//  Parametrised successor to the single issue->EX register: an in-order DEPTH-entry buffer between

---
 rtl/issue_dispatch_buffer_pkg.sv | 19 +
 rtl/issue_dispatch_buffer_if.sv | 42 ++++
 rtl/issue_dispatch_buffer_ring.sv | 63 ++++++
 rtl/issue_dispatch_buffer.sv | 119 +++++++++++
 4 files changed

// File: rtl/issue_dispatch_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | issue_dispatch_pkg                                                       |
// | Shared defaults and channel-legality helper for issue_dispatch_buffer.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package issue_dispatch_pkg;

  localparam int unsigned c_PAYLOAD_W_DEF = 128;
  localparam int unsigned c_NR_CH_DEF     = 4;
  localparam int unsigned c_DEPTH_DEF     = 2;
  localparam int unsigned c_STALL_W_DEF   = 16;

  function automatic logic ch_legal(input int unsigned idx, input int unsigned nr_ch);
    return idx < nr_ch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_dispatch_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | issue_dispatch_buffer_if                                                 |
// | Issue-side input handshake and per-channel FU dispatch bundle.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface issue_dispatch_buffer_if
  import issue_dispatch_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = c_PAYLOAD_W_DEF,
  parameter int unsigned NR_CH     = c_NR_CH_DEF,
  parameter int unsigned DEPTH     = c_DEPTH_DEF,
  parameter int unsigned STALL_W   = c_STALL_W_DEF
);

  localparam int unsigned c_CH_W  = $clog2(NR_CH) + 1;
  localparam int unsigned c_CNT_W = $clog2(DEPTH) + 1;

  logic                 flush_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [PAYLOAD_W-1:0] in_data_i;
  logic [c_CH_W-1:0]    in_ch_i;
  logic [NR_CH-1:0]     ch_valid_o;
  logic [NR_CH-1:0]     ch_ready_i;
  logic [PAYLOAD_W-1:0] ch_data_o;
  logic                 drop_o;
  logic [c_CNT_W-1:0]   count_o;
  logic [STALL_W-1:0]   stall_cnt_o;

  modport master (
    output flush_i, in_valid_i, in_data_i, in_ch_i, ch_ready_i,
    input  in_ready_o, ch_valid_o, ch_data_o, drop_o, count_o, stall_cnt_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_data_i, in_ch_i, ch_ready_i,
    output in_ready_o, ch_valid_o, ch_data_o, drop_o, count_o, stall_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/issue_dispatch_buffer_ring.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | issue_dispatch_ring                                                      |
// | In-order circular storage with wrapping pointers and occupancy counter.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module issue_dispatch_ring #(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned DEPTH   = 2,
  localparam int unsigned c_PTR_W = $clog2(DEPTH),
  localparam int unsigned c_CNT_W = c_PTR_W + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic [WIDTH-1:0]   rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [c_CNT_W-1:0] count_o
);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  // Payload storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (pop_i) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (push_i && !pop_i) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (pop_i && !push_i) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  assign rdata_o = r_mem[r_rd_ptr];
  assign full_o  = (r_count == c_CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/issue_dispatch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | issue_dispatch_buffer                                                    |
// | DEPTH-entry in-order issue->FU buffer: channel decode, illegal-channel   |
// | drop, flush and saturating stall counter. ISSUE_DISP_BYPASS_EN enables   |
// | 0-cycle bypass of an empty buffer. Rev 1.0                               |
// +--------------------------------------------------------------------------+
module issue_dispatch_buffer
  import issue_dispatch_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = c_PAYLOAD_W_DEF,
  parameter int unsigned NR_CH     = c_NR_CH_DEF,
  parameter int unsigned DEPTH     = c_DEPTH_DEF,
  parameter int unsigned STALL_W   = c_STALL_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  issue_dispatch_buffer_if.slave  bus
);

  localparam int unsigned c_CH_W  = $clog2(NR_CH) + 1;
  localparam int unsigned c_ENT_W = PAYLOAD_W + c_CH_W;
  localparam int unsigned c_CNT_W = $clog2(DEPTH) + 1;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [c_ENT_W-1:0]   w_rd_ent;
  logic [c_CNT_W-1:0]   w_count;
  logic [c_CH_W-1:0]    w_head_ch;
  logic [PAYLOAD_W-1:0] w_head_data;
  logic                 w_head_legal;
  logic                 w_head_go;
  logic                 w_head_rdy;
  logic [NR_CH-1:0]     w_head_oh;
  logic                 w_drop;
  logic                 w_stall_inc;
  logic [STALL_W-1:0]   r_stall;

  issue_dispatch_ring #(
    .WIDTH (c_ENT_W),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (bus.flush_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i ({bus.in_data_i, bus.in_ch_i}),
    .rdata_o (w_rd_ent),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign w_head_ch    = w_rd_ent[c_CH_W-1:0];
  assign w_head_data  = w_rd_ent[c_ENT_W-1:c_CH_W];
  assign w_head_legal = ch_legal(32'(w_head_ch), NR_CH);

  always_comb begin
    w_head_oh = '0;
    for (int i = 0; i < int'(NR_CH); i++) begin
      w_head_oh[i] = (w_head_ch == c_CH_W'(i));
    end
  end

  assign w_head_go   = !w_empty && !bus.flush_i;
  assign w_head_rdy  = |(w_head_oh & bus.ch_ready_i);
  // Illegal heads leave unconditionally so they can never wedge the buffer.
  assign w_drop      = w_head_go && !w_head_legal;
  assign w_pop       = (w_head_go && w_head_legal && w_head_rdy) || w_drop;
  assign w_stall_inc = w_head_go && w_head_legal && !w_head_rdy;

  assign bus.in_ready_o  = !w_full && !rst_i;
  assign bus.drop_o      = w_drop;
  assign bus.count_o     = w_count;
  assign bus.stall_cnt_o = r_stall;

`ifdef ISSUE_DISP_BYPASS_EN
  logic             w_in_legal;
  logic [NR_CH-1:0] w_in_oh;
  logic             w_byp;
  logic             w_byp_take;

  assign w_in_legal = ch_legal(32'(bus.in_ch_i), NR_CH);

  always_comb begin
    w_in_oh = '0;
    for (int i = 0; i < int'(NR_CH); i++) begin
      w_in_oh[i] = (bus.in_ch_i == c_CH_W'(i));
    end
  end

  // Bypass only when nothing older is waiting; otherwise ordering would break.
  assign w_byp      = w_empty && bus.in_valid_i && w_in_legal && !rst_i;
  assign w_byp_take = w_byp && !bus.flush_i && |(w_in_oh & bus.ch_ready_i);
  assign w_push     = bus.in_valid_i && bus.in_ready_o && !bus.flush_i && !w_byp_take;

  assign bus.ch_valid_o = bus.flush_i ? '0 :
                          w_byp ? w_in_oh :
                          (w_head_go && w_head_legal) ? w_head_oh : '0;
  assign bus.ch_data_o  = w_byp ? bus.in_data_i : (w_empty ? '0 : w_head_data);
`else
  assign w_push         = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;
  assign bus.ch_valid_o = (w_head_go && w_head_legal) ? w_head_oh : '0;
  assign bus.ch_data_o  = w_empty ? '0 : w_head_data;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall <= '0;
    end else if (w_stall_inc && (r_stall != '1)) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

endmodule
`default_nettype wire
